// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter between two byte requesters feeding a small FIFO that an
// 8N1 serializer drains onto UART_TX.
module uart_tx_arbiter #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          req0_valid,
    input  logic [7:0]                    req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [7:0]                    req1_data,
    output logic                          req1_ready,
    output logic                          UART_TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // valid/ready: a byte moves on any edge where validN & readyN are both high;
    // readyN is combinational and never depends on a pop in the same cycle.
    logic          full;
    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic          last_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_done;

    assign full       = (fifo_cnt == FULL_CNT);
    assign grant0     = !full && req0_valid && (!req1_valid || last_q);
    assign grant1     = !full && req1_valid && (!req0_valid || !last_q);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 || grant1;
    assign push_data  = grant0 ? req0_data : req1_data;

    assign UART_TX    = tx_q;
    assign tx_busy    = (state_q != IDLE) || (fifo_cnt != '0);
    assign baud_done  = (baud_q == DIV_M1);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (grant0) begin
            last_q <= 1'b0;
        end else if (grant1) begin
            last_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is registered from the current state, so the pin trails the
    // state by one cycle uniformly and every symbol still lasts exactly DIV cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at DIV=10, FIFO_DEPTH=4; a line monitor
// decodes every 8N1 frame cycle-exactly and records its start cycle.
module tb_uart_tx_arbiter;

  logic       sys_clk;
  logic       reset;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       UART_TX;
  logic       tx_busy;
  logic [2:0] fifo_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_t_q[$];
  bit         rx_ok_q[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .CLK_FREQ(100),
    .BAUD(10),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .UART_TX(UART_TX),
    .tx_busy(tx_busy),
    .fifo_cnt(fifo_cnt)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // line monitor: 100 samples per frame, one per cycle, start bit at sample 0
  initial begin
    logic [99:0] s;
    logic [7:0]  d;
    bit          aborted;
    bit          ok;
    int          t0;
    forever begin
      @(negedge sys_clk);
      if (reset === 1'b0 && UART_TX === 1'b0) begin
        t0 = cyc;
        s = '1;
        s[0] = 1'b0;
        aborted = 1'b0;
        for (int i = 1; i < 100; i++) begin
          @(negedge sys_clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          s[i] = UART_TX;
        end
        if (!aborted) begin
          ok = 1'b1;
          d = '0;
          for (int i = 0; i < 10; i++) if (s[i] !== 1'b0) ok = 1'b0;
          for (int b = 0; b < 8; b++) begin
            d[b] = s[10 + 10 * b];
            for (int i = 0; i < 10; i++) if (s[10 + 10 * b + i] !== d[b]) ok = 1'b0;
          end
          for (int i = 90; i < 100; i++) if (s[i] !== 1'b1) ok = 1'b0;
          rx_q.push_back(d);
          rx_t_q.push_back(t0);
          rx_ok_q.push_back(ok);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    rx_q.delete();
    rx_t_q.delete();
    rx_ok_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge sys_clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", UART_TX); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    int c;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    #1;
    c = cyc;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge sys_clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (fifo_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", fifo_cnt); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_early: got %b want 1", tx_busy); end
    while (cyc < c + 101) @(negedge sys_clk);
    #1;
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b want 1", tx_busy); end
    @(negedge sys_clk);
    #1;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", tx_busy); end
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b want 1", UART_TX); end
    wait_frames(1, 50);
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL single_frames: got %0d want 1", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'hA5 || !rx_ok_q[0]) begin errors++; $display("FAIL single_data: got %h ok=%0d want a5 ok=1", rx_q[0], rx_ok_q[0]); end
      checks++; if (rx_t_q[0] != c + 3) begin errors++; $display("FAIL single_latency: got %0d want %0d", rx_t_q[0] - c, 3); end
    end
  endtask

  task automatic test_simultaneous();
    int c;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    #1;
    c = cyc;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sim_first: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge sys_clk);
    req0_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL sim_second: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge sys_clk);
    req1_valid = 1'b0;
    wait_frames(2, 300);
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL sim_frames: got %0d want 2", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'h11 || !rx_ok_q[0]) begin errors++; $display("FAIL sim_byte0: got %h ok=%0d want 11", rx_q[0], rx_ok_q[0]); end
      checks++; if (rx_q[1] !== 8'h22 || !rx_ok_q[1]) begin errors++; $display("FAIL sim_byte1: got %h ok=%0d want 22", rx_q[1], rx_ok_q[1]); end
      checks++; if (rx_t_q[0] != c + 3) begin errors++; $display("FAIL sim_latency: got %0d want 3", rx_t_q[0] - c); end
      checks++; if (rx_t_q[1] - rx_t_q[0] != 101) begin errors++; $display("FAIL sim_gap: got %0d want 101", rx_t_q[1] - rx_t_q[0]); end
    end
  endtask

  task automatic test_fairness();
    int g[$];
    bit gr0;
    bit gr1;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_data = 8'h40;
    for (int i = 0; i < 400 && g.size() < 6; i++) begin
      #1;
      gr0 = req0_ready;
      gr1 = req1_ready;
      checks++; if (gr0 && gr1) begin errors++; $display("FAIL fair_exclusive: got 11 want at most one"); end
      if (gr0) begin g.push_back(0); exp_q.push_back(req0_data); end
      if (gr1) begin g.push_back(1); exp_q.push_back(req1_data); end
      @(negedge sys_clk);
      if (gr0) req0_data = req0_data + 8'd1;
      if (gr1) req1_data = req1_data + 8'd1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (g.size() != 6) begin
      errors++; $display("FAIL fair_grants: got %0d want 6", g.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (g[i] != i % 2) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, g[i], i % 2); end
      end
    end
    wait_frames(6, 800);
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL fair_frames: got %0d want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (rx_q[i] !== exp_q[i] || !rx_ok_q[i]) begin errors++; $display("FAIL fair_line[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_full();
    int acc[$];
    int maxc;
    bit gr;
    do_reset();
    maxc = 0;
    req1_valid = 1'b1;
    req1_data = 8'h01;
    for (int i = 0; i < 300 && acc.size() < 6; i++) begin
      #1;
      if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
      gr = req1_ready;
      if (gr) acc.push_back(cyc);
      @(negedge sys_clk);
      if (gr) req1_data = req1_data + 8'd1;
    end
    req1_valid = 1'b0;
    checks++; if (maxc != 4) begin errors++; $display("FAIL full_maxcnt: got %0d want 4", maxc); end
    checks++;
    if (acc.size() != 6) begin
      errors++; $display("FAIL full_accepts: got %0d want 6", acc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++; if (acc[i] - acc[0] != i) begin errors++; $display("FAIL full_stream[%0d]: got %0d want %0d", i, acc[i] - acc[0], i); end
      end
      checks++; if (acc[5] - acc[0] != 103) begin errors++; $display("FAIL full_resume: got %0d want 103", acc[5] - acc[0]); end
    end
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    wait_frames(6, 800);
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL full_frames: got %0d want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (rx_q[i] !== exp_q[i] || !rx_ok_q[i]) begin errors++; $display("FAIL full_line[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    int bad;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'hFF;
    #1;
    c = cyc;
    @(negedge sys_clk); req0_data = 8'h12;
    @(negedge sys_clk); req0_data = 8'h34;
    @(negedge sys_clk); req0_valid = 1'b0;
    while (cyc < c + 48) @(negedge sys_clk);
    #1;
    checks++; if (fifo_cnt !== 3'd2) begin errors++; $display("FAIL mid_queued: got %0d want 2", fifo_cnt); end
    reset = 1'b1;
    @(negedge sys_clk);
    #1;
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", UART_TX); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", fifo_cnt); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", tx_busy); end
    @(negedge sys_clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (UART_TX !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mid_frames: got %0d want 0", rx_q.size()); end
    req0_valid = 1'b1; req0_data = 8'h55;
    req1_valid = 1'b1; req1_data = 8'h66;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_last: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge sys_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_extremes();
    int c;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'h00;
    #1;
    c = cyc;
    @(negedge sys_clk);
    req0_data = 8'hFF;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ext_ready: got %b want 1", req0_ready); end
    @(negedge sys_clk);
    req0_valid = 1'b0;
    wait_frames(2, 300);
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL ext_frames: got %0d want 2", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'h00 || !rx_ok_q[0]) begin errors++; $display("FAIL ext_zero: got %h ok=%0d want 00", rx_q[0], rx_ok_q[0]); end
      checks++; if (rx_q[1] !== 8'hFF || !rx_ok_q[1]) begin errors++; $display("FAIL ext_ones: got %h ok=%0d want ff", rx_q[1], rx_ok_q[1]); end
      checks++; if (rx_t_q[0] != c + 3) begin errors++; $display("FAIL ext_latency: got %0d want 3", rx_t_q[0] - c); end
      checks++; if (rx_t_q[1] - rx_t_q[0] != 101) begin errors++; $display("FAIL ext_gap: got %0d want 101", rx_t_q[1] - rx_t_q[0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0;
    req0_data = 8'h00;
    req1_valid = 1'b0;
    req1_data = 8'h00;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_full();
    test_reset_mid_frame();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the board UART transmitter between two byte sources, requester 0 and requester 1. Typical sources are CPU peripheral stores and an RX echo/debug path.
- Round-robin arbitration feeds a small FIFO, and an 8N1 serializer drains it on UART_TX at the configured baud.
- Sits between the CPU peripheral bus and the UART_TX pin.

Parameters:
CLK_FREQ, 100000000, sys_clk frequency in Hz
BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD cycles per bit (integer division, 10416 at defaults)
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
sys_clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a byte
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 byte accepted this cycle
req1_valid  in  1  requester 1 has a byte
req1_data  in  8  requester 1 byte
req1_ready  out  1  requester 1 byte accepted this cycle
UART_TX  out  1  serial line, idles high, registered
tx_busy  out  1  FIFO non-empty or frame in progress
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: single clock sys_clk; reset is synchronous and active-high.
- Reset values:
  - UART_TX=1, fifo_cnt=0, tx_busy=0.
  - FSM=IDLE, baud counter=0.
  - Round-robin pointer last=1, so requester 0 wins first.
- Arbitration (combinational ready):
  - Grant only when fifo_cnt<FIFO_DEPTH. A pop in the same cycle does not free a slot for that cycle's push.
  - One valid requester: it is granted.
  - Both valid: the requester not equal to `last` is granted.
  - readyN=1 only for the granted requester. A transfer occurs when validN&readyN, and `last` updates to N.
  - At most one push per cycle. Data is written into the FIFO at that edge.
- FIFO:
  - Circular pointers that wrap modulo FIFO_DEPTH.
  - Push and pop may occur in the same cycle when the FIFO is neither full nor empty; fifo_cnt is unchanged.
  - Pop only from IDLE.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: if fifo_cnt!=0, pop the head into the shift register and go to START.
  - START: UART_TX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: UART_TX=shift[0] (LSB first) for DIV cycles per bit. Shift after each bit. After bit 7 go to STOP.
  - STOP: UART_TX=1 for DIV cycles, then go to IDLE.
  - The baud counter runs 0..DIV-1 and clears on every state/bit change.
- Latency:
  - A byte pushed at edge t into an empty FIFO is popped at edge t+1.
  - UART_TX goes low after edge t+2.
- Timing:
  - One frame is 10*DIV cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (period 10*DIV+1).
- tx_busy = (FSM!=IDLE) | (fifo_cnt!=0), combinational.
- Reset mid-frame: at the next edge, UART_TX returns to 1, the FIFO is flushed, the FSM goes to IDLE and the pointer returns to last=1. The partial frame is abandoned.
- Requester data held while ready=0 is not lost. Requesters must keep valid and data stable until ready.

Test Plan (CLK_FREQ=100, BAUD=10 => DIV=10, FIFO_DEPTH=4):
- Single byte: req0 sends 0xA5 after reset.
  - req0_ready=1 in the same cycle.
  - UART_TX goes low 2 cycles later for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - tx_busy drops after 100 frame cycles.
- Simultaneous request: req0=0x11 and req1=0x22 valid in the same cycle after reset.
  - req0 is granted first, req1 on the next cycle.
  - Line carries 0x11 then 0x22, with exactly 1 idle-high cycle between the stop bit and the start bit.
- Fairness: both requesters continuously valid with distinct bytes.
  - Grants alternate 0,1,0,1.
  - Serial output order matches grant order.
- Full FIFO: req1 streams 0x01..0x06 back-to-back.
  - Five bytes are accepted (first popped immediately), and fifo_cnt reaches 4.
  - req1_ready=0 until the cycle after the next pop.
  - 0x06 is accepted then, and all six bytes appear in order.
- Reset mid-frame: assert reset during data bit 3 of 0xFF with 2 bytes queued.
  - At the next edge UART_TX=1, fifo_cnt=0, tx_busy=0.
  - No further frames are sent.
- Data extremes: send 0x00 and 0xFF.
  - 0x00 gives low for 90 cycles then a high stop.
  - 0xFF gives low for 10 cycles then high for 90 cycles.
